// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Contents: FSM state enum, buffer entry payload, fetch widths and
// a word-alignment helper.
package fetch_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned CNT_WIDTH  = 2;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Clear the byte-offset bits so only word addresses reach memory.
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ADDR_WIDTH'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, inst} pairs between fetch and decode.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_entry at the tail (accepted if not full or popping)
//   pop         - drop the head entry (ignored when empty)
//   flush       - empty the buffer; wins over push
//   push_entry  - entry to write
//   count       - number of valid entries (0..2)
//   head        - oldest entry; stale contents when count==0, zero after reset
module fetch_buf
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  fetch_entry_t         push_entry,
    output logic [CNT_WIDTH-1:0] count,
    output fetch_entry_t         head
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BUF_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Entry 0 is always the head; entry 1 is the second-oldest.
    fetch_entry_t entry0;
    fetch_entry_t entry1;

    logic pop_ok;
    logic push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count < CNT_FULL) || pop_ok);
    assign head    = entry0;

    // Shift-style storage: a pop moves entry1 forward, a push fills the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b11: begin
                    if (count == CNT_FULL) begin
                        entry0 <= entry1;
                        entry1 <= push_entry;
                    end else begin
                        entry0 <= push_entry;
                    end
                end
                2'b10: begin
                    if (count == '0) entry0 <= push_entry;
                    else             entry1 <= push_entry;
                    count <= count + CNT_ONE;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses the
// combinational instruction memory and buffers {pc, inst} pairs for
// decode over a valid/ready handshake. Handles redirects and halts.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect
// traps into a sticky FAULT state; otherwise redirect_pc is word-aligned).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   imem_addr       - instruction memory address (the fetch PC)
//   imem_rdata      - combinational read data for imem_addr
//   inst_valid      - buffer head valid
//   inst_ready      - decode accepts the head this cycle
//   inst, inst_pc   - head instruction and its PC
//   redirect_valid  - flush and restart fetch at redirect_pc
//   redirect_pc     - new fetch target
//   halt_req        - level request to stop fetching
//   halted          - halted with an empty buffer
//   fetch_fault     - sticky misaligned-redirect trap
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  fetch_fault
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BUF_DEPTH);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_next;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [CNT_WIDTH-1:0]  count;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;

    assign redirect_target = word_align(redirect_pc);
    assign pop             = inst_valid && inst_ready;
    assign push_entry      = '{pc: fetch_pc, inst: imem_rdata};

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault;
    logic fault_next;
    logic misaligned;

    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = fault;
`else
    assign fetch_fault = 1'b0;
`endif

    // State, PC and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            halted   <= (state == HALTED) && (count == '0);
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky trap flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault <= 1'b0;
        else        fault <= fault_next;
    end
`endif

    // Next-state, fetch control and redirect handling.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        push          = 1'b0;
        flush         = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_next    = fault;
`endif

        unique case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (halt_req) state_next = HALTED;
                push = !halt_req && !redirect_valid && ((count < CNT_FULL) || pop);
            end
            HALTED: begin
                if (!halt_req) state_next = RUN;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: ;
`endif
            default: state_next = BOOT;
        endcase

        if (push) fetch_pc_next = fetch_pc + ADDR_WIDTH'(INST_BYTES);

        // Redirect outranks push and halt bookkeeping; a coincident pop is discarded.
        if (redirect_valid && (state != FAULT)) begin
            flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
                fault_next = 1'b1;
                state_next = FAULT;
            end else begin
                fetch_pc_next = redirect_target;
            end
`else
            fetch_pc_next = redirect_target;
`endif
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .count      (count),
        .head       (head)
    );

endmodule
